lut_sop_sweep: RTL and testbench
================================

// Module: lut_sop_sweep
// PURPOSE
//   Parametrised, registered successor of the fixed 4-input SOP logic cell.
//   Holds an N_IN-input truth table that can be rewritten at run time.
//   Evaluates input vectors with one cycle of latency.
//   Has a self-sweep mode that walks all 2**N_IN minterms and counts the ones (on-set size).
//   Sits between bench/CPU config logic and downstream combinational checkers.
// PARAMETERS
//   N_IN        4        number of function inputs; table depth = 2**N_IN
//   DEFAULT_TT  16'h2F22 reset truth table; bit i = F({in_vec}=i); 2F22 = A&~B | ~C&D, A = MSB
// PORTS
//   clk         in   1          rising-edge clock
//   rst         in   1          synchronous, active-high reset
//   in_vec      in   N_IN       evaluation input, MSB = first variable
//   f_out       out  1          registered table[in_vec] of previous cycle
//   cfg_we      in   1          write strobe for one truth-table entry
//   cfg_addr    in   N_IN       entry index to write
//   cfg_bit     in   1          value to write
//   cfg_busy    out  1          high while sweeping; cfg_we ignored when high
//   start       in   1          one-cycle pulse: begin sweep
//   sweep_valid out  1          sweep_idx/sweep_f valid this cycle
//   sweep_idx   out  N_IN       minterm index being reported
//   sweep_f     out  1          table[sweep_idx]
//   done        out  1          one-cycle pulse, sweep complete
//   ones_count  out  N_IN+1     on-set size; final value valid from done, held until next start/rst
// BEHAVIOUR
//   Reset (sync, rst=1 at edge)
//     - table <= DEFAULT_TT; state <= IDLE.
//     - f_out, sweep_valid, sweep_f, done, cfg_busy <= 0; sweep_idx, ones_count <= 0.
//     - Reset mid-sweep aborts the sweep: no done pulse, count cleared.
//   Evaluate
//     - f_out <= table[in_vec] every cycle in all states.
//     - Latency is 1 clock.
//     - Same-cycle write to that entry: f_out returns the OLD value; the new value is visible next cycle.
//   Configure
//     - cfg_we=1 and state != SWEEP: table[cfg_addr] <= cfg_bit at the edge.
//     - During SWEEP, writes are dropped silently, so the sweep always sees a stable table.
//   FSM (states IDLE, SWEEP, DONE)
//     - IDLE  --start-->      SWEEP; idx <= 0; ones_count <= 0; cfg_busy <= 1.
//     - SWEEP: each cycle sweep_valid=1, sweep_idx=idx, sweep_f=table[idx].
//         ones_count += table[idx]; idx++.
//         On idx == 2**N_IN-1 go to DONE (no wrap to 0 reported).
//     - DONE: done=1 for exactly one cycle, sweep_valid=0, cfg_busy=0; then IDLE.
//     - start while in SWEEP or DONE is ignored; start in the same cycle as rst is ignored.
//   Timing
//     - start sampled at edge t.
//     - sweep_valid high for edges t+1 .. t+2**N_IN, carrying indices 0..2**N_IN-1.
//     - done is high after edge t+2**N_IN+1.
//   Width rules
//     - ones_count is N_IN+1 bits wide, so an all-ones table (2**N_IN) does not overflow.
//     - idx is N_IN bits; the terminal compare is against all-ones.
// STRUCTURE
//   - Package lut_sweep_pkg: typedef enum {IDLE, SWEEP, DONE} sweep_state_t; function tt_depth(n) = 2**n.
//   - Sub-module lut_tt_reg: 2**N_IN-bit table register.
//       Synchronous reset to DEFAULT_TT, one write port, two combinational read ports (eval, sweep).
//   - Top: FSM, idx counter, ones accumulator, output registers.
// TESTING
//   1. Reset, then in_vec sweep 0..15 (N_IN=4, default table):
//        f_out one cycle late = 0,1,0,0,0,1,0,0,1,1,1,1,0,1,0,0.
//   2. start with default table:
//        16 sweep_valid cycles with idx 0..15; done one cycle later; ones_count=7.
//   3. Write addr 0 <- 1 while in_vec=0:
//        f_out=0 that cycle, 1 the next; sweep then gives ones_count=8.
//   4. cfg_we (addr 3, bit 1) during SWEEP:
//        cfg_busy=1, write dropped, ones_count stays 7; extra start pulses ignored.
//   5. rst at sweep idx 9:
//        next cycle sweep_valid=0, ones_count=0, no done; table back to 0x2F22.
//   6. N_IN=2, DEFAULT_TT=4'hF:
//        4 valid cycles, ones_count=4 (3-bit, no overflow).

Source files
------------

// File: rtl/lut_sweep_pkg.sv
// lut_sweep_pkg: sweep FSM state type and truth-table depth helper
package lut_sweep_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} sweep_state_t;
  function automatic int tt_depth(input int n);
    return 2 ** n;
  endfunction
endpackage

// File: rtl/lut_sop_sweep_if.sv
// lut_sop_sweep_if: eval/config/sweep bus; master = config/bench side, slave = lut_sop_sweep
interface lut_sop_sweep_if #(parameter int N_IN = 4);
  logic [N_IN-1:0] in_vec;
  logic            f_out;
  logic            cfg_we;
  logic [N_IN-1:0] cfg_addr;
  logic            cfg_bit;
  logic            cfg_busy;
  logic            start;
  logic            sweep_valid;
  logic [N_IN-1:0] sweep_idx;
  logic            sweep_f;
  logic            done;
  logic [N_IN:0]   ones_count;
  modport master (output in_vec, cfg_we, cfg_addr, cfg_bit, start,
                  input f_out, cfg_busy, sweep_valid, sweep_idx, sweep_f, done, ones_count);
  modport slave (input in_vec, cfg_we, cfg_addr, cfg_bit, start,
                 output f_out, cfg_busy, sweep_valid, sweep_idx, sweep_f, done, ones_count);
endinterface

// File: rtl/lut_tt_reg.sv
// lut_tt_reg: truth-table register, one write port (i_we/i_addr/i_bit), reads o_eval at i_eval_addr and o_sweep at i_sweep_addr
module lut_tt_reg import lut_sweep_pkg::*; #(
  parameter int N_IN = 4,
  parameter logic [tt_depth(N_IN)-1:0] DEFAULT_TT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [N_IN-1:0] i_addr,
  input  logic            i_bit,
  input  logic [N_IN-1:0] i_eval_addr,
  input  logic [N_IN-1:0] i_sweep_addr,
  output logic            o_eval,
  output logic            o_sweep
);
  logic [tt_depth(N_IN)-1:0] r_tt;
  always_ff @(posedge clk)
    if (rst) r_tt <= DEFAULT_TT;
    else if (i_we) r_tt[i_addr] <= i_bit;
  assign o_eval = r_tt[i_eval_addr];
  assign o_sweep = r_tt[i_sweep_addr];
endmodule

// File: rtl/lut_sop_sweep.sv
// lut_sop_sweep: run-time rewritable N_IN-input LUT, registered eval, self-sweep on-set counter; ports clk, rst, bus (slave)
module lut_sop_sweep import lut_sweep_pkg::*; #(
  parameter int N_IN = 4,
  parameter logic [tt_depth(N_IN)-1:0] DEFAULT_TT = 16'h2F22
) (
  input logic            clk,
  input logic            rst,
  lut_sop_sweep_if.slave bus
);
  sweep_state_t    r_state, w_next;
  logic [N_IN-1:0] r_idx, r_sweep_idx;
  logic [N_IN:0]   r_ones;
  logic            r_f_out, r_sweep_valid, r_sweep_f, r_done, r_busy;
  logic            w_we, w_eval_f, w_sweep_f;
  assign w_we = bus.cfg_we && r_state != SWEEP;
  lut_tt_reg #(.N_IN(N_IN), .DEFAULT_TT(DEFAULT_TT)) u_tt (
    .clk(clk), .rst(rst), .i_we(w_we), .i_addr(bus.cfg_addr), .i_bit(bus.cfg_bit),
    .i_eval_addr(bus.in_vec), .i_sweep_addr(r_idx), .o_eval(w_eval_f), .o_sweep(w_sweep_f)
  );
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = bus.start ? SWEEP : IDLE;
    else if (r_state == SWEEP) w_next = (r_idx == '1) ? DONE : SWEEP;
  end
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (rst) begin
      r_idx <= '0;
      r_sweep_idx <= '0;
      r_ones <= '0;
      r_f_out <= 1'b0;
      r_sweep_valid <= 1'b0;
      r_sweep_f <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_f_out <= w_eval_f;
      r_sweep_valid <= r_state == SWEEP;
      r_done <= r_state == DONE;
      if (r_state == SWEEP) begin
        r_sweep_idx <= r_idx;
        r_sweep_f <= w_sweep_f;
        r_ones <= r_ones + (N_IN+1)'(w_sweep_f);
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == IDLE && bus.start) begin
        r_idx <= '0;
        r_ones <= '0;
        r_busy <= 1'b1;
      end
      if (r_state == DONE) r_busy <= 1'b0;
    end
  assign bus.f_out = r_f_out;
  assign bus.cfg_busy = r_busy;
  assign bus.sweep_valid = r_sweep_valid;
  assign bus.sweep_idx = r_sweep_idx;
  assign bus.sweep_f = r_sweep_f;
  assign bus.done = r_done;
  assign bus.ones_count = r_ones;
endmodule

// File: tb/tb_lut_sop_sweep.sv
// tb_lut_sop_sweep: directed checks of eval, config, sweep, reset abort and a 2-input instance
module tb_lut_sop_sweep;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_tot = 0;
  logic [15:0] tt_model = 16'h2F22;
  lut_sop_sweep_if #(.N_IN(4)) b4 ();
  lut_sop_sweep_if #(.N_IN(2)) b2 ();
  lut_sop_sweep #(.N_IN(4), .DEFAULT_TT(16'h2F22)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  lut_sop_sweep #(.N_IN(2), .DEFAULT_TT(4'hF)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_sweep(input int exp_ones, input bit poke);
    b4.start = 1'b1;
    tick();
    b4.start = poke;
    b4.cfg_we = poke;
    b4.cfg_addr = 4'd3;
    b4.cfg_bit = 1'b1;
    chk("busy_start", b4.cfg_busy, 1);
    chk("valid_pre", b4.sweep_valid, 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("valid_%0d", k), b4.sweep_valid, 1);
      chk($sformatf("idx_%0d", k), b4.sweep_idx, k);
      chk($sformatf("sf_%0d", k), b4.sweep_f, tt_model[k]);
      if (poke) chk($sformatf("busy_%0d", k), b4.cfg_busy, 1);
    end
    b4.cfg_we = 1'b0;
    tick();
    chk("done", b4.done, 1);
    chk("valid_done", b4.sweep_valid, 0);
    chk("busy_done", b4.cfg_busy, 0);
    chk("ones", b4.ones_count, exp_ones);
    b4.start = 1'b0;
    tick();
    chk("done_pulse", b4.done, 0);
    chk("valid_after", b4.sweep_valid, 0);
    chk("ones_held", b4.ones_count, exp_ones);
  endtask
  initial begin
    b4.in_vec = '0; b4.cfg_we = 1'b0; b4.cfg_addr = '0; b4.cfg_bit = 1'b0; b4.start = 1'b0;
    b2.in_vec = '0; b2.cfg_we = 1'b0; b2.cfg_addr = '0; b2.cfg_bit = 1'b0; b2.start = 1'b0;
    b4.start = 1'b1;
    tick();
    tick();
    b4.start = 1'b0;
    chk("rst_f", b4.f_out, 0);
    chk("rst_valid", b4.sweep_valid, 0);
    chk("rst_done", b4.done, 0);
    chk("rst_busy", b4.cfg_busy, 0);
    chk("rst_ones", b4.ones_count, 0);
    chk("rst_idx", b4.sweep_idx, 0);
    rst = 1'b0;
    tick();
    chk("rst_start_ignored", b4.sweep_valid, 0);
    for (int i = 0; i < 16; i++) begin
      b4.in_vec = 4'(i);
      tick();
      chk($sformatf("eval_%0d", i), b4.f_out, tt_model[i]);
    end
    run_sweep(7, 1'b0);
    b4.in_vec = 4'd0;
    b4.cfg_we = 1'b1; b4.cfg_addr = 4'd0; b4.cfg_bit = 1'b1;
    tick();
    b4.cfg_we = 1'b0;
    chk("wr_old", b4.f_out, 0);
    tick();
    chk("wr_new", b4.f_out, 1);
    tt_model[0] = 1'b1;
    run_sweep(8, 1'b0);
    b4.cfg_we = 1'b1; b4.cfg_addr = 4'd0; b4.cfg_bit = 1'b0;
    tick();
    b4.cfg_we = 1'b0;
    tt_model[0] = 1'b0;
    run_sweep(7, 1'b1);
    b4.in_vec = 4'd3;
    tick();
    chk("drop_f", b4.f_out, 0);
    b4.cfg_we = 1'b1; b4.cfg_addr = 4'd3; b4.cfg_bit = 1'b1;
    tick();
    b4.cfg_we = 1'b0;
    tick();
    chk("wr3_f", b4.f_out, 1);
    tt_model[3] = 1'b1;
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("abort_idx", b4.sweep_idx, 9);
    chk("abort_valid_pre", b4.sweep_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", b4.sweep_valid, 0);
    chk("abort_ones", b4.ones_count, 0);
    chk("abort_busy", b4.cfg_busy, 0);
    chk("abort_done", b4.done, 0);
    tt_model = 16'h2F22;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("abort_nodone_%0d", k), b4.done | b4.sweep_valid, 0);
    end
    chk("rst_tt_f", b4.f_out, 0);
    run_sweep(7, 1'b0);
    b2.in_vec = 2'd2;
    b2.start = 1'b1;
    tick();
    b2.start = 1'b0;
    chk("n2_f", b2.f_out, 1);
    chk("n2_busy", b2.cfg_busy, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("n2_valid_%0d", k), b2.sweep_valid, 1);
      chk($sformatf("n2_idx_%0d", k), b2.sweep_idx, k);
      chk($sformatf("n2_sf_%0d", k), b2.sweep_f, 1);
    end
    tick();
    chk("n2_done", b2.done, 1);
    chk("n2_valid_done", b2.sweep_valid, 0);
    chk("n2_ones", b2.ones_count, 4);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
